// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - address map, TCTRL bit indices and target decode for data_bus_ctrl
package dbus_pkg;

   localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
   localparam logic [2:0]  OFF_LED    = 3'd0;
   localparam logic [2:0]  OFF_SW     = 3'd1;
   localparam logic [2:0]  OFF_TCOUNT = 3'd2;
   localparam logic [2:0]  OFF_TCMP   = 3'd3;
   localparam logic [2:0]  OFF_TCTRL  = 3'd4;
   localparam logic [2:0]  OFF_TSTAT  = 3'd5;

   localparam int TCTRL_EN = 0;
   localparam int TCTRL_AR = 1;

   typedef enum logic [2:0] {
      TGT_RAM,
      TGT_LED,
      TGT_SW,
      TGT_TIMER,
      TGT_NONE
   } tgt_e;

   // Timer offsets only decode when the timer is actually built.
   function automatic tgt_e dbus_decode(input logic [31:0] addr,
                                        input logic [31:0] ram_depth,
                                        input logic        timer_en);
      tgt_e tgt;
      tgt = TGT_NONE;
      if (addr < ram_depth) begin
         tgt = TGT_RAM;
      end else if (addr[31:3] == MMIO_BASE[31:3]) begin
         case (addr[2:0])
            OFF_LED:    tgt = TGT_LED;
            OFF_SW:     tgt = TGT_SW;
            OFF_TCOUNT,
            OFF_TCMP,
            OFF_TCTRL,
            OFF_TSTAT:  tgt = timer_en ? TGT_TIMER : TGT_NONE;
            default:    tgt = TGT_NONE;
         endcase
      end
      return tgt;
   endfunction

endpackage

// File: rtl/data_bus_ctrl_if.sv
// rtl/data_bus_ctrl_if.sv - CPU data-port request/response bundle
interface data_bus_ctrl_if;
   logic        write;
   logic        read;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output write, read, address, wdata, input rdata);
   modport slave  (input write, read, address, wdata, output rdata);
endinterface

// File: rtl/dbus_timer.sv
// rtl/dbus_timer.sv - compare timer: TCOUNT/TCMP/TCTRL and sticky match flag
module dbus_timer
   import dbus_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [2:0]  off,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        flag
);

   logic [31:0] tcount;
   logic [31:0] tcmp;
   logic [1:0]  tctrl;
   logic        match;

   assign match = tctrl[TCTRL_EN] && (tcount == tcmp);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcount <= '0;
         tcmp   <= '0;
         tctrl  <= '0;
         flag   <= 1'b0;
      end else begin
         if (tctrl[TCTRL_EN])
            tcount <= (match && tctrl[TCTRL_AR]) ? 32'd0 : tcount + 32'd1;
         // CPU writes come after the count update so they take precedence.
         if (we) begin
            case (off)
               OFF_TCOUNT: tcount <= wdata;
               OFF_TCMP:   tcmp   <= wdata;
               OFF_TCTRL:  tctrl  <= wdata[1:0];
               default:    ;
            endcase
         end
         if (match)
            flag <= 1'b1;
         else if (we && off == OFF_TSTAT && wdata[0])
            flag <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      case (off)
         OFF_TCOUNT: rdata = tcount;
         OFF_TCMP:   rdata = tcmp;
         OFF_TCTRL:  rdata = {30'd0, tctrl};
         OFF_TSTAT:  rdata = {31'd0, flag};
         default:    rdata = '0;
      endcase
   end

endmodule

// File: rtl/data_bus_ctrl.sv
// rtl/data_bus_ctrl.sv - data-side bus slave decoding RAM, LED/SW and timer
// Timer and its registers are built only when DBUS_TIMER_EN is defined.
module data_bus_ctrl
   import dbus_pkg::*;
#(
   parameter int          RAM_DEPTH      = 1024,
   parameter int          SW_WIDTH       = 16,
   parameter logic [31:0] UNMAPPED_RDATA = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   data_bus_ctrl_if.slave      bus,
   input  logic [SW_WIDTH-1:0] sw,
   output logic [SW_WIDTH-1:0] led,
   output logic                bus_err,
   output logic                timer_irq
);

   localparam int AW = $clog2(RAM_DEPTH);

`ifdef DBUS_TIMER_EN
   localparam logic TIMER_EN = 1'b1;
`else
   localparam logic TIMER_EN = 1'b0;
`endif

   tgt_e                tgt;
   logic [AW-1:0]       ram_idx;
   logic [31:0]         mem [RAM_DEPTH];
   logic [SW_WIDTH-1:0] sw_s1;
   logic [SW_WIDTH-1:0] sw_s2;
   logic [31:0]         timer_rdata;

   assign tgt     = dbus_decode(bus.address, 32'(RAM_DEPTH), TIMER_EN);
   assign ram_idx = bus.address[AW-1:0];

   always_ff @(posedge clk) begin
      if (bus.write && tgt == TGT_RAM)
         mem[ram_idx] <= bus.wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led     <= '0;
         sw_s1   <= '0;
         sw_s2   <= '0;
         bus_err <= 1'b0;
      end else begin
         sw_s1   <= sw;
         sw_s2   <= sw_s1;
         bus_err <= (bus.read || bus.write) && tgt == TGT_NONE;
         if (bus.write && tgt == TGT_LED)
            led <= bus.wdata[SW_WIDTH-1:0];
      end
   end

`ifdef DBUS_TIMER_EN
   dbus_timer u_timer (
      .clk   (clk),
      .rst   (rst),
      .we    (bus.write && tgt == TGT_TIMER),
      .off   (bus.address[2:0]),
      .wdata (bus.wdata),
      .rdata (timer_rdata),
      .flag  (timer_irq)
   );
`else
   assign timer_rdata = '0;
   assign timer_irq   = 1'b0;
`endif

   // Reads see pre-edge state, so a simultaneous write is not visible yet.
   always_comb begin
      bus.rdata = '0;
      if (bus.read) begin
         case (tgt)
            TGT_RAM:   bus.rdata = mem[ram_idx];
            TGT_LED:   bus.rdata = 32'(led);
            TGT_SW:    bus.rdata = 32'(sw_s2);
            TGT_TIMER: bus.rdata = timer_rdata;
            default:   bus.rdata = UNMAPPED_RDATA;
         endcase
      end
   end

endmodule
